ex_mdu: RTL
===========

Name: ex_mdu

Overview:
- Parametrised iterative multiply/divide execution unit implementing the RV32M/RV64M operations. It sits beside the single-cycle ALU in the EX stage.
- It accepts one operation at a time and holds the pipeline through stall_req_o while it iterates.
- It presents a one-cycle write-back result (enable/addr/data) when the operation completes.
- Multiply throughput is tunable by unrolling. Division is radix-2 restoring.

Parameters:
- XLEN, 32, operand/result width in bits (32 or 64).
- MUL_UNROLL, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4, 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- r1_data_i  in  XLEN  rs1 operand (multiplicand/dividend).
- r2_data_i  in  XLEN  rs2 operand (multiplier/divisor).
- w_enable_i  in  1  instruction writes rd.
- w_addr_i  in  5  rd index.
- flush_i  in  1  abort current operation (branch redirect / exception).
- busy_o  out  1  state != IDLE.
- stall_req_o  out  1  pipeline hold request.
- done_o  out  1  one-cycle completion pulse.
- w_enable_o  out  1  write-back enable, qualified.
- w_addr_o  out  5  write-back rd.
- w_data_o  out  XLEN  result.

Behaviour:
- FSM states are IDLE, CALC and FINISH.
- Reset (rst=1 at clk edge):
  - state becomes IDLE.
  - busy_o, done_o and w_enable_o become 0.
  - w_addr_o becomes 0 and w_data_o becomes 0.
  - Reset has priority over flush and start in every state, including mid-operation.
- IDLE with start_i=1 and flush_i=0 (cycle 0):
  - Latch op, rd and w_enable.
  - Latch operand magnitudes: absolute value for signed operand positions. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Latch the result sign flags:
    - multiply: sign(rs1) XOR sign(rs2).
    - quotient: sign(dividend) XOR sign(divisor).
    - remainder: sign(dividend).
  - Clear the accumulator and counter.
- Fast paths: in IDLE, start with any of the following goes directly to FINISH and sets the result register:
  - Division by zero (r2_data_i == 0):
    - DIV/DIVU result = all ones.
    - REM/REMU result = r1_data_i.
  - Signed overflow (DIV/REM with r1 = 1 followed by XLEN-1 zeros, r2 = all ones):
    - DIV result = r1_data_i.
    - REM result = 0.
  - Otherwise: multiply ops go to CALC with count N = XLEN/MUL_UNROLL; divide ops go to CALC with count N = XLEN.
- CALC:
  - Multiply: shift-add MUL_UNROLL multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: one restoring step per cycle (shift remainder left, trial subtract, set quotient bit).
  - After N cycles, transition to FINISH. During this transition:
    - Apply sign correction (two's-complement negate if the sign flag is set).
    - Select the result slice: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
    - Write the result to w_data_o.
- FINISH (exactly one cycle):
  - done_o = 1.
  - w_enable_o = latched w_enable AND (rd != 0).
  - w_addr_o = rd, or 0 when suppressed.
  - Next state is IDLE.
  - In all other cycles done_o = 0 and w_enable_o = 0.
  - w_data_o holds its value until the next completion.
- Latency from start cycle 0:
  - Multiply: done in cycle N+1 (XLEN=32, UNROLL=1 → cycle 33).
  - Divide: done in cycle 33.
  - Fast path: done in cycle 1.
- stall_req_o (combinational) = (state==IDLE && start_i && !flush_i) || state==CALC.
  - It is low in FINISH, so the pipeline advances together with the result.
- start_i outside IDLE is ignored; there is no queueing. A start in the FINISH cycle is not accepted; the upstream stage re-presents it, since stall is released.
- flush_i:
  - In any state, the next state is IDLE.
  - No done_o is raised; w_enable_o = 0.
  - Flush with start in the same IDLE cycle: flush wins and the start is dropped.
  - Flush during FINISH: the done pulse in that cycle still occurs, because the write was already committed by the pipeline's timing.
- Arithmetic:
  - All intermediate widths are exact: 2*XLEN for the product, XLEN+1 for the trial subtraction.
  - The most-negative operand's magnitude is represented correctly in XLEN unsigned bits.

Test Plan:
- MUL 7 × 0xFFFFFFFD, rd=5, XLEN=32, UNROLL=1 → stall_req_o high cycles 0–32; done_o in cycle 33; w_data_o=0xFFFFFFEB, w_addr_o=5, w_enable_o=1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; all with done_o at cycle 33.
- DIVU 5/0 → 0xFFFFFFFF with done_o in cycle 1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush and reset:
  - Start MUL, assert flush_i in cycle 10 → busy_o=0 in cycle 11; no done_o.
  - A new start in cycle 11 completes normally.
  - rst in cycle 5 of a DIV → all outputs 0 the next cycle.
- MUL with rd=0 → done_o=1, w_enable_o=0, w_addr_o=0. With MUL_UNROLL=4, MUL 0x12345678 × 0x10 → done_o in cycle 9; w_data_o=0x23456780.

Source files
------------

// File: rtl/ex_mdu_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the execution unit is the slave.
interface ex_mdu_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] r1_data_i;
    logic [XLEN-1:0] r2_data_i;
    logic            w_enable_i;
    logic [4:0]      w_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_req_o;
    logic            done_o;
    logic            w_enable_o;
    logic [4:0]      w_addr_o;
    logic [XLEN-1:0] w_data_o;

    modport master (
        output start_i, op_i, r1_data_i, r2_data_i, w_enable_i, w_addr_i, flush_i,
        input  busy_o, stall_req_o, done_o, w_enable_o, w_addr_o, w_data_o
    );

    modport slave (
        input  start_i, op_i, r1_data_i, r2_data_i, w_enable_i, w_addr_i, flush_i,
        output busy_o, stall_req_o, done_o, w_enable_o, w_addr_o, w_data_o
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: unrolled shift-add multiplier and
// radix-2 restoring divider on operand magnitudes, with sign fix-up at completion.
module ex_mdu #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic     clk,
    input  logic     rst,
    ex_mdu_if.slave  bus
);
    localparam int              CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(XLEN / MUL_UNROLL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          op_r;
    logic [4:0]          rd_r;
    logic                wen_r;
    logic                neg_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     mplier_r;
    logic [XLEN-1:0]     divisor_r;
    logic [XLEN-1:0]     rem_r;
    logic [XLEN-1:0]     quo_r;
    logic                done_r;
    logic                w_enable_r;
    logic [4:0]          w_addr_r;
    logic [XLEN-1:0]     w_data_r;

    logic                is_div_s;
    logic                rs1_signed_s;
    logic                rs2_signed_s;
    logic                r1_neg_s;
    logic                r2_neg_s;
    logic [XLEN-1:0]     r1_mag_s;
    logic [XLEN-1:0]     r2_mag_s;
    logic                neg_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic [XLEN-1:0]     fast_res_s;
    logic                fast_wen_s;

    // Operand decode: signedness, magnitudes, sign flag and fast-path detection.
    always_comb begin
        is_div_s     = bus.op_i[2];
        rs1_signed_s = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                       (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
        rs2_signed_s = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
        r1_neg_s     = rs1_signed_s & bus.r1_data_i[XLEN-1];
        r2_neg_s     = rs2_signed_s & bus.r2_data_i[XLEN-1];
        // Negating the most-negative value yields 2^(XLEN-1), which is exact as unsigned.
        r1_mag_s     = r1_neg_s ? (ZERO - bus.r1_data_i) : bus.r1_data_i;
        r2_mag_s     = r2_neg_s ? (ZERO - bus.r2_data_i) : bus.r2_data_i;
        neg_s        = (bus.op_i == 3'b110) ? r1_neg_s : (r1_neg_s ^ r2_neg_s);
        div_zero_s   = is_div_s && (bus.r2_data_i == ZERO);
        div_ovf_s    = ((bus.op_i == 3'b100) || (bus.op_i == 3'b110)) &&
                       (bus.r1_data_i == MOST_NEG) && (bus.r2_data_i == ALL_ONES);
        fast_wen_s   = bus.w_enable_i && (bus.w_addr_i != 5'd0);
        if (div_zero_s) begin
            fast_res_s = bus.op_i[1] ? bus.r1_data_i : ALL_ONES;
        end else if (div_ovf_s) begin
            fast_res_s = bus.op_i[1] ? ZERO : bus.r1_data_i;
        end else begin
            fast_res_s = ZERO;
        end
    end

    logic [2*XLEN-1:0]   mul_add_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [XLEN:0]       rem_shift_s;
    logic                ge_s;
    logic [XLEN-1:0]     rem_next_s;
    logic [XLEN-1:0]     quo_next_s;
    logic [2*XLEN-1:0]   prod_fin_s;
    logic [XLEN-1:0]     quo_fin_s;
    logic [XLEN-1:0]     rem_fin_s;
    logic [XLEN-1:0]     result_s;

    // One iteration of each datapath plus the sign-corrected result of that iteration.
    always_comb begin
        mul_add_s = {(2*XLEN){1'b0}};
        for (int k = 0; k < MUL_UNROLL; k++) begin
            mul_add_s = mul_add_s + (mplier_r[k] ? (mcand_r << k) : {(2*XLEN){1'b0}});
        end
        acc_next_s  = acc_r + mul_add_s;
        rem_shift_s = {rem_r, quo_r[XLEN-1]};
        ge_s        = rem_shift_s >= {1'b0, divisor_r};
        // The remainder stays below the divisor, so the difference fits in XLEN bits.
        rem_next_s  = ge_s ? (rem_shift_s[XLEN-1:0] - divisor_r) : rem_shift_s[XLEN-1:0];
        quo_next_s  = {quo_r[XLEN-2:0], ge_s};
        prod_fin_s  = neg_r ? ({(2*XLEN){1'b0}} - acc_next_s) : acc_next_s;
        quo_fin_s   = neg_r ? (ZERO - quo_next_s) : quo_next_s;
        rem_fin_s   = neg_r ? (ZERO - rem_next_s) : rem_next_s;
        case (op_r)
            3'b000:                 result_s = prod_fin_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_s = prod_fin_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_s = quo_fin_s;
            3'b110, 3'b111:         result_s = rem_fin_s;
            default:                result_s = ZERO;
        endcase
    end

    // Control FSM, operand/iteration registers and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            op_r       <= 3'b000;
            rd_r       <= 5'd0;
            wen_r      <= 1'b0;
            neg_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            mcand_r    <= {(2*XLEN){1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            mplier_r   <= ZERO;
            divisor_r  <= ZERO;
            rem_r      <= ZERO;
            quo_r      <= ZERO;
            done_r     <= 1'b0;
            w_enable_r <= 1'b0;
            w_addr_r   <= 5'd0;
            w_data_r   <= ZERO;
        end else if (bus.flush_i) begin
            state_r    <= IDLE;
            done_r     <= 1'b0;
            w_enable_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            w_enable_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_i) begin
                        op_r      <= bus.op_i;
                        rd_r      <= bus.w_addr_i;
                        wen_r     <= bus.w_enable_i;
                        neg_r     <= neg_s;
                        mcand_r   <= {{XLEN{1'b0}}, r1_mag_s};
                        mplier_r  <= r2_mag_s;
                        acc_r     <= {(2*XLEN){1'b0}};
                        divisor_r <= r2_mag_s;
                        rem_r     <= ZERO;
                        quo_r     <= r1_mag_s;
                        cnt_r     <= is_div_s ? DIV_CNT : MUL_CNT;
                        if (div_zero_s || div_ovf_s) begin
                            state_r    <= FINISH;
                            w_data_r   <= fast_res_s;
                            done_r     <= 1'b1;
                            w_enable_r <= fast_wen_s;
                            w_addr_r   <= fast_wen_s ? bus.w_addr_i : 5'd0;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << MUL_UNROLL;
                    mplier_r <= mplier_r >> MUL_UNROLL;
                    rem_r    <= rem_next_s;
                    quo_r    <= quo_next_s;
                    cnt_r    <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r    <= FINISH;
                        w_data_r   <= result_s;
                        done_r     <= 1'b1;
                        w_enable_r <= wen_r && (rd_r != 5'd0);
                        w_addr_r   <= (wen_r && (rd_r != 5'd0)) ? rd_r : 5'd0;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FINISH:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = (state_r != IDLE);
    assign bus.stall_req_o = ((state_r == IDLE) && bus.start_i && !bus.flush_i) || (state_r == CALC);
    assign bus.done_o      = done_r;
    assign bus.w_enable_o  = w_enable_r;
    assign bus.w_addr_o    = w_addr_r;
    assign bus.w_data_o    = w_data_r;
endmodule
